// File: rtl/adc_channel_aligner.sv
// rtl/adc_channel_aligner.sv - per-channel ADC sample FIFOs with aligned word output and overflow tracking
module adc_channel_aligner #(
    parameter int NUM_CH      = 2,
    parameter int SAMPLE_W    = 11,
    parameter int DEPTH       = 8,
    parameter int PRIME_LEVEL = 3,
    parameter int DROP_CNT_W  = 16,
    parameter int AUTO_RESYNC = 1
) (
    input  logic                         system_clock,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         resync,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*SAMPLE_W-1:0]   out_data,
    output logic [NUM_CH-1:0]            overflow,
    input  logic                         clear_flags,
    output logic [DROP_CNT_W-1:0]        drop_count,
    output logic                         aligned
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SAMPLE_W-1:0] mem [NUM_CH][DEPTH];
    logic [PTR_W-1:0]    wr_ptr [NUM_CH];
    logic [PTR_W-1:0]    rd_ptr [NUM_CH];
    logic [OCC_W-1:0]    occ [NUM_CH];

    logic                       all_nonempty;
    logic                       all_primed;
    logic                       pop;
    logic                       abort;
    logic [NUM_CH-1:0]          wr_ok;
    logic [NUM_CH-1:0]          drop;
    logic [CNT_W-1:0]           drop_num;
    logic [DROP_CNT_W:0]        drop_sum;
    logic [NUM_CH*SAMPLE_W-1:0] head_word;

    assign abort   = resync | ~enable;
    assign pop     = (state == STREAM) & all_nonempty & (~out_valid | out_ready);
    assign aligned = (state == STREAM);
    assign drop_sum = {1'b0, drop_count} + (DROP_CNT_W + 1)'(drop_num);

    // Occupancy summaries across channels and the word formed by all FIFO heads (channel 0 in the MSBs)
    always_comb begin
        all_nonempty = 1'b1;
        all_primed   = 1'b1;
        head_word    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (occ[c] == '0) all_nonempty = 1'b0;
            if (occ[c] < OCC_W'(PRIME_LEVEL)) all_primed = 1'b0;
            head_word[(NUM_CH-1-c)*SAMPLE_W +: SAMPLE_W] = mem[c][rd_ptr[c]];
        end
    end

    // Write acceptance: a full FIFO still takes a sample when the same cycle pops it
    always_comb begin
        wr_ok    = '0;
        drop     = '0;
        drop_num = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_valid[c] && enable && (state != FLUSH)) begin
                if ((occ[c] != OCC_W'(DEPTH)) || pop) begin
                    wr_ok[c] = 1'b1;
                end else begin
                    drop[c]  = 1'b1;
                    drop_num = drop_num + CNT_W'(1);
                end
            end
        end
    end

    // Next-state: external abort beats overflow realignment, which beats normal progress
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = FLUSH;
        end else if ((AUTO_RESYNC != 0) && (drop != '0)) begin
            state_next = FLUSH;
        end else begin
            case (state)
                FLUSH:   state_next = PRIME;
                PRIME:   if (all_primed) state_next = STREAM;
                STREAM:  state_next = STREAM;
                default: state_next = FLUSH;
            endcase
        end
    end

    // State register
    always_ff @(posedge system_clock or negedge resetn) begin
        if (!resetn) begin
            state <= FLUSH;
        end else begin
            state <= state_next;
        end
    end

    // FIFO pointers and occupancies; the FLUSH cycle empties every channel
    always_ff @(posedge system_clock or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                occ[c]    <= '0;
            end
        end else if (state == FLUSH) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                occ[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_ok[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop)      rd_ptr[c] <= rd_ptr[c] + 1'b1;
                occ[c] <= occ[c] + OCC_W'(wr_ok[c]) - OCC_W'(pop);
            end
        end
    end

    // Sample storage; contents need no reset since occupancy gates every read
    always_ff @(posedge system_clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_ok[c]) mem[c][wr_ptr[c]] <= in_data[(NUM_CH-1-c)*SAMPLE_W +: SAMPLE_W];
        end
    end

    // Output register: any move into or through FLUSH aborts the held word without a handshake
    always_ff @(posedge system_clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if ((state == FLUSH) || (state_next == FLUSH)) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= head_word;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overflow flags and saturating drop counter; a same-cycle drop beats clear_flags
    always_ff @(posedge system_clock or negedge resetn) begin
        if (!resetn) begin
            overflow   <= '0;
            drop_count <= '0;
        end else if (clear_flags) begin
            overflow   <= drop;
            drop_count <= DROP_CNT_W'(drop_num);
        end else begin
            overflow <= overflow | drop;
            if (drop_sum[DROP_CNT_W]) begin
                drop_count <= '1;
            end else begin
                drop_count <= drop_sum[DROP_CNT_W-1:0];
            end
        end
    end

endmodule
